ascon_duplex_stream: RTL

Sequential, parametrised ASCON duplex engine for the encryption/decryption data phase. It takes a 320-bit post-associated-data state, then streams any number of rate-sized blocks in either mode through valid/ready handshakes. It applies the p_b permutation iteratively between blocks and pads the final partial block. It returns the pre-finalisation state for the tag stage, and succeeds the fixed two-block combinational decryption datapath.

---
 rtl/ascon_pkg.sv | 43 ++++
 rtl/ascon_round.sv | 46 ++++
 rtl/ascon_duplex_stream.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/ascon_pkg.sv
// Shared types and constants for the ASCON duplex engine: state layout,
// round-constant schedule, linear-layer rotation amounts and the FSM encoding.
package ascon_pkg;

    // x0 is declared first so it occupies the MSBs of a flat 320-bit vector.
    typedef struct packed {
        logic [63:0] x0;
        logic [63:0] x1;
        logic [63:0] x2;
        logic [63:0] x3;
        logic [63:0] x4;
    } ascon_state_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ABSORB  = 2'd1,
        PERMUTE = 2'd2,
        DONE    = 2'd3
    } fsm_t;

    localparam int ROT0_A = 19;
    localparam int ROT0_B = 28;
    localparam int ROT1_A = 61;
    localparam int ROT1_B = 39;
    localparam int ROT2_A = 1;
    localparam int ROT2_B = 6;
    localparam int ROT3_A = 10;
    localparam int ROT3_B = 17;
    localparam int ROT4_A = 7;
    localparam int ROT4_B = 41;

    // A reduced permutation runs the tail of the 12-round schedule.
    function automatic logic [7:0] round_const(input int rounds, input int k);
        int j;
        j = 12 - rounds + k;
        return {4'(15 - j), 4'(j)};
    endfunction

    function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational ASCON round: constant addition, bit-sliced 5-bit S-box
// and the per-word linear diffusion layer.
module ascon_round
    import ascon_pkg::*;
(
    input  ascon_state_t state_in,
    input  logic [7:0]   rc,
    output ascon_state_t state_out
);

    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;

    always_comb begin
        x0 = state_in.x0;
        x1 = state_in.x1;
        x2 = state_in.x2 ^ {56'd0, rc};
        x3 = state_in.x3;
        x4 = state_in.x4;

        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;

        state_out.x0 = x0 ^ ror64(x0, ROT0_A) ^ ror64(x0, ROT0_B);
        state_out.x1 = x1 ^ ror64(x1, ROT1_A) ^ ror64(x1, ROT1_B);
        state_out.x2 = x2 ^ ror64(x2, ROT2_A) ^ ror64(x2, ROT2_B);
        state_out.x3 = x3 ^ ror64(x3, ROT3_A) ^ ror64(x3, ROT3_B);
        state_out.x4 = x4 ^ ror64(x4, ROT4_A) ^ ror64(x4, ROT4_B);
    end

endmodule

// File: rtl/ascon_duplex_stream.sv
// Streaming ASCON duplex data phase: absorbs/squeezes rate blocks in either
// mode, runs p_b iteratively between blocks and hands back the padded state.
module ascon_duplex_stream
    import ascon_pkg::*;
#(
    parameter int RATE_W   = 64,
    parameter int ROUNDS_B = 6,
    parameter int UNROLL   = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         load_valid,
    output logic                         load_ready,
    input  logic [319:0]                 state_in,
    input  logic                         mode,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [RATE_W-1:0]            in_data,
    input  logic                         in_last,
    input  logic [$clog2(RATE_W/8)-1:0]  in_bytes,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [RATE_W-1:0]            out_data,
    output logic                         out_last,
    output logic [$clog2(RATE_W/8)-1:0]  out_bytes,
    output logic                         done_valid,
    input  logic                         done_ready,
    output logic [319:0]                 state_out
);

    localparam int RBYTES = RATE_W / 8;
    localparam int BW     = $clog2(RBYTES);

    fsm_t              fsm_q, fsm_d;
    ascon_state_t      st_q, st_absorb, st_perm;
    logic              mode_q;
    logic [3:0]        rnd_q;
    logic              out_valid_q;
    logic [RATE_W-1:0] out_data_q;
    logic              out_last_q;
    logic [BW-1:0]     out_bytes_q;

    logic              load_hs, in_hs, perm_last;
    int                nbytes;
    logic [127:0]      rate_wide, rate_wide_new;
    logic [RATE_W-1:0] rate_cur, rate_new, out_blk;

    assign perm_last = (fsm_q == PERMUTE) && (int'(rnd_q) + UNROLL >= ROUNDS_B);
    assign load_hs   = load_valid && load_ready;
    assign in_hs     = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) fsm_q <= IDLE;
        else        fsm_q <= fsm_d;
    end

    always_comb begin
        // NOTE: every output gets a default before the case so no branch can
        // leave one unassigned and infer a latch.
        fsm_d      = fsm_q;
        load_ready = 1'b0;
        in_ready   = 1'b0;
        done_valid = 1'b0;
        case (fsm_q)
            IDLE: begin
                load_ready = rst_n;
                if (load_valid && rst_n) fsm_d = ABSORB;
            end
            ABSORB: begin
                in_ready = !out_valid_q || out_ready;
                if (in_valid && in_ready) fsm_d = in_last ? DONE : PERMUTE;
            end
            PERMUTE: begin
                if (perm_last) fsm_d = ABSORB;
            end
            DONE: begin
                done_valid = 1'b1;
                if (done_ready) fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    // The rate is always the top RATE_W bits of {x0,x1}; x1 stays capacity at 64.
    always_comb begin
        rate_wide = {st_q.x0, st_q.x1};
        rate_cur  = rate_wide[127 -: RATE_W];
        nbytes    = in_last ? int'(in_bytes) : RBYTES;
        out_blk   = '0;
        rate_new  = rate_cur;
        for (int i = 0; i < RBYTES; i++) begin
            if (i < nbytes) begin
                out_blk[RATE_W-1-8*i -: 8]  = rate_cur[RATE_W-1-8*i -: 8] ^ in_data[RATE_W-1-8*i -: 8];
                rate_new[RATE_W-1-8*i -: 8] = mode_q ? in_data[RATE_W-1-8*i -: 8]
                                                     : out_blk[RATE_W-1-8*i -: 8];
            end else if (in_last && i == nbytes) begin
                rate_new[RATE_W-1-8*i -: 8] = rate_cur[RATE_W-1-8*i -: 8] ^ 8'h80;
            end
        end
        rate_wide_new                  = rate_wide;
        rate_wide_new[127 -: RATE_W]   = rate_new;
        st_absorb                      = st_q;
        st_absorb.x0                   = rate_wide_new[127:64];
        st_absorb.x1                   = rate_wide_new[63:0];
    end

    ascon_state_t chain [UNROLL+1];
    assign chain[0] = st_q;

    for (genvar u = 0; u < UNROLL; u++) begin : g_round
        logic [7:0] rc;
        assign rc = round_const(ROUNDS_B, int'(rnd_q) + u);
        ascon_round u_round (
            .state_in  (chain[u]),
            .rc        (rc),
            .state_out (chain[u+1])
        );
    end

    assign st_perm = chain[UNROLL];

    always_ff @(posedge clk) begin
        // NOTE: the wide state is cleared on reset rather than left as-is so a
        // previous message's secret state can never surface on state_out.
        if (!rst_n) begin
            st_q        <= '0;
            mode_q      <= 1'b0;
            rnd_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_bytes_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge
            // values regardless of statement order.
            if (load_hs) begin
                st_q   <= state_in;
                mode_q <= mode;
            end else if (in_hs) begin
                st_q <= st_absorb;
            end else if (fsm_q == PERMUTE) begin
                st_q <= st_perm;
            end

            if (fsm_q == PERMUTE && !perm_last) rnd_q <= rnd_q + 4'(UNROLL);
            else                                rnd_q <= '0;

            if (in_hs) begin
                out_valid_q <= 1'b1;
                out_data_q  <= out_blk;
                out_last_q  <= in_last;
                out_bytes_q <= in_bytes;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_bytes = out_bytes_q;
    assign state_out = st_q;

endmodule
